// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall / redirect flush sequencer; optional perf counters via HAZARD_CTRL_PERF_CNT_EN
module hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_redirect,
  output logic       pc_hold,
  output logic       if_id_hold,
  output logic       if_flush,
  output logic       id_ex_bubble,
  output logic       busy
`ifdef HAZARD_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             w_hazard;
  assign w_hazard = ex_mem_read && ex_rd != 5'd0 &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  // state and window counter register; reset abandons any open window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end
  // next state and same-cycle outputs; redirect beats everything, hazard only seen in RUN
  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_flush     = 1'b0;
    id_ex_bubble = 1'b0;
    busy         = rst_n && r_state != RUN;
    if (!rst_n) begin
      w_next       = RUN;
      w_cnt_next   = '0;
      if_flush     = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (ex_redirect) begin
      if_flush     = 1'b1;
      id_ex_bubble = 1'b1;
      w_next       = FLUSH_CYCLES > 1 ? FLUSH : RUN;
      w_cnt_next   = FLUSH_CYCLES > 1 ? CNT_W'(FLUSH_CYCLES - 1) : '0;
    end else if (r_state == STALL) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_bubble = 1'b1;
      w_cnt_next   = r_cnt - CNT_W'(1);
      w_next       = r_cnt == CNT_W'(1) ? RUN : STALL;
    end else if (r_state == FLUSH) begin
      if_flush     = 1'b1;
      id_ex_bubble = 1'b1;
      w_cnt_next   = r_cnt - CNT_W'(1);
      w_next       = r_cnt == CNT_W'(1) ? RUN : FLUSH;
    end else if (w_hazard) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_bubble = 1'b1;
      w_next       = STALL_CYCLES > 1 ? STALL : RUN;
      w_cnt_next   = STALL_CYCLES > 1 ? CNT_W'(STALL_CYCLES - 1) : '0;
    end
  end
`ifdef HAZARD_CTRL_PERF_CNT_EN
  logic [31:0] r_stall_count, r_flush_count;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
  // cycle counters for stalled and flushed cycles, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_stall_count <= r_stall_count + {31'd0, pc_hold};
      r_flush_count <= r_flush_count + {31'd0, if_flush};
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + random check of hazard_ctrl against a window-counting reference model
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic [4:0] o_a, o_b;
  int         checks = 0;
  int         errors = 0;
  int         s_len [2] = '{1, 3};
  int         f_len [2] = '{1, 2};
  int         kind [2];
  int         left [2];
  logic [31:0] m_sc [2];
  logic [31:0] m_fc [2];
  always #5 clk = ~clk;
  hazard_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .pc_hold(o_a[4]), .if_id_hold(o_a[3]),
    .if_flush(o_a[2]), .id_ex_bubble(o_a[1]), .busy(o_a[0])
`ifdef HAZARD_CTRL_PERF_CNT_EN
    , .stall_count(sc_a), .flush_count(fc_a)
`endif
  );
  hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .pc_hold(o_b[4]), .if_id_hold(o_b[3]),
    .if_flush(o_b[2]), .id_ex_bubble(o_b[1]), .busy(o_b[0])
`ifdef HAZARD_CTRL_PERF_CNT_EN
    , .stall_count(sc_b), .flush_count(fc_b)
`endif
  );
`ifdef HAZARD_CTRL_PERF_CNT_EN
  logic [31:0] sc_a, fc_a, sc_b, fc_b;
`endif
  function automatic logic hz();
    return ex_mem_read && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction
  // expected {pc_hold, if_id_hold, if_flush, id_ex_bubble, busy}; kind 0 idle, 1 stall window, 2 flush window
  function automatic logic [4:0] expect_out(int k);
    logic bz;
    bz = kind[k] != 0;
    if (!rst_n) return 5'b00110;
    if (ex_redirect) return {4'b0011, bz};
    if (kind[k] == 1) return 5'b11011;
    if (kind[k] == 2) return 5'b00111;
    if (hz()) return 5'b11010;
    return 5'b00000;
  endfunction
  task automatic cyc(input logic r, input logic [4:0] a, input logic [4:0] b, input logic u1,
                     input logic u2, input logic mr, input logic [4:0] rd, input logic rdir);
    logic [4:0] e, o;
    @(negedge clk);
    rst_n = r; id_rs1 = a; id_rs2 = b; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_mem_read = mr; ex_rd = rd; ex_redirect = rdir;
    #1;
    for (int k = 0; k < 2; k++) begin
      e = expect_out(k);
      o = k == 0 ? o_a : o_b;
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL outputs dut%0d: observed %b expected %b", k, o, e);
      end
      checks++;
      assert (!(o[3] && o[2])) else begin
        errors++;
        $error("FAIL hold_vs_flush dut%0d: observed %b expected 0", k, o[3] & o[2]);
      end
`ifdef HAZARD_CTRL_PERF_CNT_EN
      if (rst_n) begin
        checks++;
        assert ((k == 0 ? sc_a : sc_b) === m_sc[k]) else begin
          errors++;
          $error("FAIL stall_count dut%0d: observed %0d expected %0d", k, k == 0 ? sc_a : sc_b, m_sc[k]);
        end
        checks++;
        assert ((k == 0 ? fc_a : fc_b) === m_fc[k]) else begin
          errors++;
          $error("FAIL flush_count dut%0d: observed %0d expected %0d", k, k == 0 ? fc_a : fc_b, m_fc[k]);
        end
      end
`endif
      if (!rst_n) begin
        kind[k] = 0; left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        m_sc[k] = m_sc[k] + {31'd0, e[4]};
        m_fc[k] = m_fc[k] + {31'd0, e[2]};
        if (ex_redirect) begin
          left[k] = f_len[k] - 1;
          kind[k] = left[k] > 0 ? 2 : 0;
        end else if (kind[k] != 0) begin
          left[k]--;
          if (left[k] == 0) kind[k] = 0;
        end else if (hz()) begin
          left[k] = s_len[k] - 1;
          kind[k] = left[k] > 0 ? 1 : 0;
        end
      end
    end
    @(posedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      kind[k] = 0; left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 5, 0, 1, 0, 1, 5, 0);
    idle(4);
    cyc(1, 0, 0, 1, 0, 1, 0, 0);
    cyc(1, 0, 7, 0, 0, 1, 7, 0);
    cyc(1, 3, 7, 1, 1, 1, 7, 0);
    idle(4);
    cyc(1, 5, 0, 1, 0, 1, 5, 1);
    idle(3);
    cyc(1, 5, 0, 1, 0, 1, 5, 0);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    cyc(1, 5, 0, 1, 0, 1, 5, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 39) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
          $urandom_range(0, 9) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
